// File: rtl/mips_loader_pkg.sv
// mips_loader_pkg: shared FSM states and stream framing constants for program_loader
//   LEN_BYTES  : bytes in the little-endian word-count header
//   WORD_BYTES : bytes per instruction word
package mips_loader_pkg;
  typedef enum logic [2:0] {LEN0, LEN1, DATA, CSUM, DONE, ERR} state_t;
  localparam int LEN_BYTES = 2;
  localparam int WORD_BYTES = 4;
endpackage

// File: rtl/program_loader_if.sv
// program_loader_if: byte-stream handshake plus instruction-memory write port
//   in_valid/in_data/in_ready : byte stream, transfer when valid and ready
//   imem_we/imem_addr/imem_wdata : one-cycle word write strobe, address, data
//   master = stream source / memory sink side, slave = program_loader side
interface program_loader_if #(parameter int ADDR_W = 8);
  logic in_valid;
  logic [7:0] in_data;
  logic in_ready;
  logic imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0] imem_wdata;
  modport master(output in_valid, in_data, input in_ready, imem_we, imem_addr, imem_wdata);
  modport slave(input in_valid, in_data, output in_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/program_loader_word_packer.sv
// word_packer: assembles LSB-first bytes into 32-bit words
//   clr        : drop any partial word (lane back to 0)
//   in_en      : accept in_byte this cycle
//   lane       : index of the next byte within the current word
//   word_valid : one-cycle pulse the cycle after the last byte of a word
//   word       : assembled word, stable while word_valid is high
module word_packer
  import mips_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        in_en,
  input  logic [7:0]  in_byte,
  output logic [1:0]  lane,
  output logic        word_valid,
  output logic [31:0] word
);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      lane <= '0;
      word_valid <= 1'b0;
      word <= '0;
    end else begin
      word_valid <= in_en && lane == 2'(WORD_BYTES - 1);
      if (clr) lane <= '0;
      else if (in_en) begin
        lane <= lane + 2'd1;
        // shifting in from the top leaves the first byte in [7:0] after four bytes
        word <= {in_byte, word[31:8]};
      end
    end
endmodule

// File: rtl/program_loader.sv
// program_loader: streams a length-prefixed program into instruction memory
//   clk, reset   : clock, asynchronous active-high reset
//   bus          : byte stream in, instruction-memory write port out
//   reload       : pulse in DONE/ERR to start a new load
//   cpu_reset    : holds the processor in reset until a load completes
//   done, error  : registered load status
//   words_loaded : words written during the current load
//   Optional macro LOADER_CHECKSUM_EN adds a mod-256 checksum trailer byte.
module program_loader
  import mips_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  program_loader_if.slave      bus,
  input  logic                 reload,
  output logic                 cpu_reset,
  output logic                 done,
  output logic                 error,
  output logic [15:0]          words_loaded
);
`ifdef LOADER_CHECKSUM_EN
  localparam state_t FIN = CSUM;
  logic [7:0] sum;
`else
  localparam state_t FIN = DONE;
`endif
  state_t state, nxt;
  logic rdy_en, acc, wv, last_byte;
  logic [7:0] len_lo;
  logic [15:0] n, len_in;
  logic [1:0] lane;
  logic [31:0] word;
  logic [ADDR_W-1:0] addr;
  // rdy_en keeps in_ready low until the first edge after reset releases
  assign bus.in_ready = rdy_en && state inside {LEN0, LEN1, DATA, CSUM};
  assign acc = bus.in_valid && bus.in_ready;
  assign len_in = {bus.in_data, len_lo};
  assign last_byte = acc && state == DATA && lane == 2'(WORD_BYTES - 1);
  assign bus.imem_we = wv;
  assign bus.imem_wdata = word;
  assign bus.imem_addr = addr;
  word_packer u_packer (
    .clk(clk),
    .reset(reset),
    .clr(state != DATA),
    .in_en(acc && state == DATA),
    .in_byte(bus.in_data),
    .lane(lane),
    .word_valid(wv),
    .word(word)
  );
  always_comb begin
    nxt = state;
    case (state)
      LEN0: nxt = acc ? LEN1 : LEN0;
      LEN1: if (acc) nxt = len_in == 16'd0 ? FIN : (32'(len_in) > MAX_WORDS ? ERR : DATA);
`ifdef LOADER_CHECKSUM_EN
      // leave DATA as the last byte lands so a trailer sent next cycle lands in CSUM
      DATA: if (last_byte && words_loaded + 16'd1 == n) nxt = CSUM;
      CSUM: nxt = acc ? (bus.in_data == sum ? DONE : ERR) : CSUM;
`else
      // wait for the final write strobe so DONE strictly follows it
      DATA: if (wv && words_loaded == n) nxt = DONE;
`endif
      DONE, ERR: nxt = reload ? LEN0 : state;
      default: nxt = LEN0;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= LEN0;
      rdy_en <= 1'b0;
      len_lo <= '0;
      n <= '0;
      addr <= '0;
      words_loaded <= '0;
      done <= 1'b0;
      error <= 1'b0;
      cpu_reset <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      sum <= '0;
`endif
    end else begin
      state <= nxt;
      rdy_en <= 1'b1;
      done <= nxt == DONE;
      error <= nxt == ERR;
      cpu_reset <= nxt != DONE;
      if (acc && state == LEN0) len_lo <= bus.in_data;
      if (acc && state == LEN1) n <= len_in;
      if (reload && state inside {DONE, ERR}) words_loaded <= '0;
      else if (last_byte) begin
        words_loaded <= words_loaded + 16'd1;
        addr <= words_loaded[ADDR_W-1:0];
      end
`ifdef LOADER_CHECKSUM_EN
      if (state == LEN0) sum <= '0;
      else if (acc && state == DATA) sum <= sum + bus.in_data;
`endif
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: table-driven plus hand-written sequences with a write scoreboard
module tb_program_loader;
  localparam int ADDR_W = 8;
  localparam int MAX_WORDS = 256;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic reload = 1'b0;
  logic cpu_reset, done, error;
  logic [15:0] words_loaded;
  program_loader_if #(.ADDR_W(ADDR_W)) bus ();
  program_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .reload(reload),
    .cpu_reset(cpu_reset),
    .done(done),
    .error(error),
    .words_loaded(words_loaded)
  );
  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0] data;
  } wr_t;
  typedef struct {
    string name;
    int len;
    logic [7:0] b[16];
    bit gap;
    bit exp_done;
    bit exp_err;
    int exp_words;
  } vec_t;

  wr_t sb[$];
  wr_t e;
  vec_t vt[6];
  int checks = 0;
  int errors = 0;
  logic prev_we = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard: every write strobe must match the oldest expected write and be one cycle wide
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      chk("we_width", {31'd0, prev_we}, 32'd0);
      if (sb.size() == 0) chk("unexpected_write", {24'd0, bus.imem_addr}, 32'hFFFFFFFF);
      else begin
        e = sb.pop_front();
        chk("wr_addr", {24'd0, bus.imem_addr}, {24'd0, e.addr});
        chk("wr_data", bus.imem_wdata, e.data);
      end
    end
    prev_we = bus.imem_we;
  end

  // reference model: length header, then LSB-first words; oversized loads write nothing
  function automatic void expect_stream(input logic [7:0] s[$]);
    int n;
    wr_t w;
    n = int'({s[1], s[0]});
    if (n > MAX_WORDS) return;
    for (int k = 0; k < n; k++) begin
      w.addr = ADDR_W'(k);
      w.data = {s[2+4*k+3], s[2+4*k+2], s[2+4*k+1], s[2+4*k]};
      sb.push_back(w);
    end
  endfunction

  function automatic logic [7:0] csum_of(input logic [7:0] s[$]);
    logic [7:0] c = 8'd0;
    for (int k = 2; k < s.size(); k++) c = c + s[k];
    return c;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_data = b;
    while (bus.in_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t == 20) chk("in_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] q[$], input bit gap);
    foreach (q[k]) begin
      send_byte(q[k]);
      if (gap) @(negedge clk);
    end
  endtask

  task automatic wait_end();
    int t = 0;
    while (!(done === 1'b1 || error === 1'b1) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t == 100) chk("end_timeout", 32'd0, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    chk("reload_done", {31'd0, done}, 32'd0);
    chk("reload_error", {31'd0, error}, 32'd0);
    chk("reload_words", {16'd0, words_loaded}, 32'd0);
    chk("reload_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("reload_in_ready", {31'd0, bus.in_ready}, 32'd1);
  endtask

  task automatic check_end(input string name, input bit d, input bit er, input int w);
    chk({name, "_done"}, {31'd0, done}, {31'd0, d});
    chk({name, "_error"}, {31'd0, error}, {31'd0, er});
    chk({name, "_words"}, {16'd0, words_loaded}, 32'(w));
    chk({name, "_cpu_reset"}, {31'd0, cpu_reset}, {31'd0, !d});
    chk({name, "_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
    chk({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  // load one stream through the model, appending the trailer byte when the checksum is built in
  task automatic run_stream(input logic [7:0] q[$], input bit gap);
    logic [7:0] s[$];
    s = q;
    expect_stream(s);
`ifdef LOADER_CHECKSUM_EN
    if (int'({s[1], s[0]}) <= MAX_WORDS) s.push_back(csum_of(q));
`endif
    send_bytes(s, gap);
    wait_end();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    bus.in_valid = 1'b0;
    bus.in_data = 8'd0;
    vt[0] = '{"basic", 10, '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h20, 8'hFF, 8'h00, 8'h00, 8'h10, 0, 0, 0, 0, 0, 0}, 1'b0, 1'b1, 1'b0, 2};
    vt[1] = '{"toggle", 10, '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h20, 8'hFF, 8'h00, 8'h00, 8'h10, 0, 0, 0, 0, 0, 0}, 1'b1, 1'b1, 1'b0, 2};
    vt[2] = '{"empty", 2, '{8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 1'b0, 1'b1, 1'b0, 0};
    vt[3] = '{"over513", 2, '{8'h01, 8'h02, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 1'b0, 1'b0, 1'b1, 0};
    vt[4] = '{"three", 14, '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 0, 0}, 1'b0, 1'b1, 1'b0, 3};
    vt[5] = '{"over257", 2, '{8'h01, 8'h01, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 1'b0, 1'b0, 1'b1, 0};
    #2 reset = 1'b1;
    #1;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_words", {16'd0, words_loaded}, 32'd0);
    chk("rst_we", {31'd0, bus.imem_we}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1 chk("ready_before_edge", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    chk("ready_after_edge", {31'd0, bus.in_ready}, 32'd1);

    for (int i = 0; i < 6; i++) begin
      q.delete();
      for (int k = 0; k < vt[i].len; k++) q.push_back(vt[i].b[k]);
      run_stream(q, vt[i].gap);
      check_end(vt[i].name, vt[i].exp_done, vt[i].exp_err, vt[i].exp_words);
      do_reload();
    end

    // reload in LEN1 must be ignored; DONE is visible on the following sample
    send_byte(8'h00);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    send_byte(8'h00);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    @(negedge clk);
    chk("zero_done_timing", {31'd0, done}, 32'd1);
    chk("zero_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    chk("zero_no_write", 32'(sb.size()), 32'd0);
    do_reload();

    // reset in the middle of a word discards it; the next load starts at address 0
    q = '{8'h02, 8'h00, 8'h13, 8'h00};
    send_bytes(q, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("mid_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("mid_we", {31'd0, bus.imem_we}, 32'd0);
    chk("mid_addr", {24'd0, bus.imem_addr}, 32'd0);
    chk("mid_wdata", bus.imem_wdata, 32'd0);
    chk("mid_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h20, 8'hFF, 8'h00, 8'h00, 8'h10};
    run_stream(q, 1'b0);
    check_end("after_reset", 1'b1, 1'b0, 2);
    do_reload();

`ifdef LOADER_CHECKSUM_EN
    q = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
    sb.push_back('{8'h00, 32'h04030201});
    send_bytes(q, 1'b0);
    wait_end();
    check_end("csum_good", 1'b1, 1'b0, 1);
    do_reload();
    q = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0B};
    sb.push_back('{8'h00, 32'h04030201});
    send_bytes(q, 1'b0);
    wait_end();
    check_end("csum_bad", 1'b0, 1'b1, 1);
    do_reload();
    q = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
    sb.push_back('{8'h00, 32'h04030201});
    send_bytes(q, 1'b0);
    wait_end();
    check_end("csum_retry", 1'b1, 1'b0, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
